// File: rtl/instruction_fetch_unit.sv
// IF stage: PC register, imem addressing, stall/redirect bubbles, RUN/HALT FSM.
// Optional single-step debug gating via `define DEBUG_STEP_EN.
module instruction_fetch_unit #(
  parameter int B = 32,
  parameter int W = 7,
  parameter logic [B-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [W-1:0] branch_target,
  input  logic         jump,
  input  logic [W-1:0] jump_target,
`ifdef DEBUG_STEP_EN
  input  logic         step,
`endif
  input  logic [B-1:0] imem_data,
  output logic [W-1:0] imem_addr,
  output logic [B-1:0] pc_incrementado_out,
  output logic [B-1:0] instruction_out,
  output logic         halted,
  output logic [31:0]  fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  state_t       state;
  logic [W-1:0] pc;
  logic [W-1:0] pc_inc;
  logic [W-1:0] pc_next;
  logic         hold;
  logic         bubble;
  logic         issue;
  logic         halt_hit;
  logic         frozen;
  logic         do_jump;
  logic         do_br;
  logic         do_adv;

`ifdef DEBUG_STEP_EN
  assign hold = stall | ~step;
`else
  assign hold = stall;
`endif

  assign pc_inc   = pc + W'(1);
  assign bubble   = hold | branch_taken | jump;
  assign issue    = (state == RUN) & ~bubble;
  assign halt_hit = issue & (imem_data == HALT_WORD);

  assign imem_addr           = pc;
  assign pc_incrementado_out = {{(B-W){1'b0}}, pc_inc};
  assign instruction_out     = issue ? imem_data : '0;

  // One-hot next-PC select, highest priority first
  assign frozen  = (state == HALT) | hold | halt_hit;
  assign do_jump = ~frozen & jump;
  assign do_br   = ~frozen & ~jump & branch_taken;
  assign do_adv  = ~frozen & ~jump & ~branch_taken;

  always_comb begin
    pc_next = pc;
    unique case (1'b1)
      frozen:  pc_next = pc;
      do_jump: pc_next = jump_target;
      do_br:   pc_next = branch_target;
      do_adv:  pc_next = pc_inc;
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      state       <= RUN;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc          <= pc_next;
      fetch_count <= fetch_count + 32'(issue);
      if (halt_hit) begin
        state  <= HALT;
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed scenarios then random
// controls, checked against a queue-fed reference of PC/issue/count behaviour.
module tb_instruction_fetch_unit;

  localparam int B = 32;
  localparam int W = 7;
  localparam int N = 1 << W;
  localparam logic [B-1:0] HW = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         stall = 1'b0;
  logic         branch_taken = 1'b0;
  logic [W-1:0] branch_target = '0;
  logic         jump = 1'b0;
  logic [W-1:0] jump_target = '0;
  logic         step = 1'b1;
  logic [B-1:0] imem_data;
  logic [W-1:0] imem_addr;
  logic [B-1:0] pc_incrementado_out;
  logic [B-1:0] instruction_out;
  logic         halted;
  logic [31:0]  fetch_count;

  logic [B-1:0] mem [N];

  assign imem_data = mem[imem_addr];

  instruction_fetch_unit #(.B(B), .W(W), .HALT_WORD(HW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall               (stall),
    .branch_taken        (branch_taken),
    .branch_target       (branch_target),
    .jump                (jump),
    .jump_target         (jump_target),
`ifdef DEBUG_STEP_EN
    .step                (step),
`endif
    .imem_data           (imem_data),
    .imem_addr           (imem_addr),
    .pc_incrementado_out (pc_incrementado_out),
    .instruction_out     (instruction_out),
    .halted              (halted),
    .fetch_count         (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned pc;
    int unsigned inc;
    int unsigned instr;
    int unsigned hlt;
    int unsigned cnt;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  // reference state
  int unsigned m_pc = 0;
  int unsigned m_cnt = 0;
  bit m_halt = 0;
  bit m_valid = 0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h at t=%0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", 32'(imem_addr), e.pc);
      chk("pc_inc", pc_incrementado_out, e.inc);
      chk("instr", instruction_out, e.instr);
      chk("halted", 32'(halted), e.hlt);
      chk("fetch_count", fetch_count, e.cnt);
    end
  end

  // One clock: apply controls, predict outputs for this cycle, advance model.
  task automatic cyc(input bit r, input bit s, input bit br, input int bt,
                     input bit j, input int jt, input bit stp = 1'b1);
    bit held;
    bit issued;
    exp_t e;
    reset = r; stall = s; branch_taken = br; branch_target = W'(bt);
    jump = j; jump_target = W'(jt); step = stp;
`ifdef DEBUG_STEP_EN
    held = s || !stp;
`else
    held = s;
`endif
    issued = !m_halt && !held && !br && !j;
    if (m_valid) begin
      e.pc    = m_pc;
      e.inc   = (m_pc + 1) % N;
      e.instr = issued ? mem[m_pc] : 0;
      e.hlt   = m_halt;
      e.cnt   = m_cnt;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_pc = 0; m_cnt = 0; m_halt = 0; m_valid = 1;
    end else if (m_valid && !m_halt && !held) begin
      if (j) m_pc = jt % N;
      else if (br) m_pc = bt % N;
      else if (mem[m_pc] == HW) begin
        m_halt = 1; m_cnt++;
      end else begin
        m_pc = (m_pc + 1) % N; m_cnt++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 32'(i + 100);
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle(5);
    // now at pc=5: stall two cycles
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    idle(3);
    // pc=8 redirects
    cyc(0, 0, 1, 40, 0, 0);
    cyc(0, 0, 0, 0, 1, 8);
    cyc(0, 0, 1, 40, 1, 60);
    cyc(0, 0, 0, 0, 1, 8);
    cyc(0, 1, 0, 0, 1, 60);
    cyc(0, 1, 1, 40, 0, 0);
    // wrap-around
    cyc(0, 0, 0, 0, 1, 126);
    idle(3);
    // halt at pc=12
    mem[12] = HW;
    cyc(0, 0, 0, 0, 1, 12);
    idle(1);
    cyc(0, 0, 0, 0, 1, 30);
    cyc(0, 1, 1, 50, 0, 0);
    idle(2);
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);
`ifdef DEBUG_STEP_EN
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 1'b0);
    cyc(1, 0, 1, 3, 1, 4, 1'b0);
`endif
    // random phase; halt word stays at 12 plus one random slot
    mem[$urandom_range(N-1)] = HW;
    for (int i = 0; i < 600; i++) begin
      bit r, s, br, j, stp;
      r   = ($urandom_range(99) < 2) || (m_halt && $urandom_range(3) == 0);
      s   = $urandom_range(99) < 20;
      br  = $urandom_range(99) < 15;
      j   = $urandom_range(99) < 10;
      stp = $urandom_range(99) < 80;
      cyc(r, s, br, $urandom_range(N-1), j, $urandom_range(N-1), stp);
    end
    idle(2);
    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
